// File: rtl/spi_controller_if.sv
// ============================================================================
// Module      : spi_controller_if
// Description : Host request and SPI pin bundle for spi_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       copi;
    logic       ncs;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, sclk, copi, ncs
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, sclk, copi, ncs
    );
endinterface

`default_nettype wire

// File: rtl/spi_controller.sv
// ============================================================================
// Module      : spi_controller
// Description : Mode-0 SPI initiator sending one 16-bit {rw, addr, wdata} frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_controller #(
    parameter int CLK_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_controller_if.slave   bus
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_controller: CLK_DIV must be within 2..255");
        end
    endgenerate

    localparam int                 c_CNT_W   = $clog2(CLK_DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic [15:0]        r_frame;
    logic               r_sclk;
    logic               r_copi;
    logic               r_ncs;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [3:0]         w_bit_nxt;
    logic [15:0]        w_frame_nxt;
    logic               w_sclk_nxt;
    logic               w_copi_nxt;
    logic               w_ncs_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_cnt_last;
    logic [3:0]         w_bit_dec;

    assign w_cnt_last = (r_cnt == c_CNT_MAX);
    assign w_bit_dec  = r_bit - 4'd1;

    // All pins are registered so they change cleanly one cycle after the decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 4'd15;
            r_frame <= 16'h0000;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_ncs   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_frame <= w_frame_nxt;
            r_sclk  <= w_sclk_nxt;
            r_copi  <= w_copi_nxt;
            r_ncs   <= w_ncs_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_frame_nxt = r_frame;
        w_sclk_nxt  = r_sclk;
        w_copi_nxt  = r_copi;
        w_ncs_nxt   = r_ncs;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ncs_nxt  = 1'b1;
                w_sclk_nxt = 1'b0;
                w_copi_nxt = 1'b0;
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
                w_bit_nxt  = 4'd15;
                if (bus.start) begin
                    w_frame_nxt = {bus.rw, bus.addr, bus.wdata};
                    w_state_nxt = S_SHIFT;
                    w_ncs_nxt   = 1'b0;
                    w_copi_nxt  = bus.rw;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_SHIFT: begin
                if (!w_cnt_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // End of a high half: next bit goes out with the falling edge.
                        w_sclk_nxt = 1'b0;
                        if (r_bit == 4'd0) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_bit_nxt  = w_bit_dec;
                            w_copi_nxt = r_frame[w_bit_dec];
                        end
                    end
                end
            end

            S_HOLD: begin
                if (!w_cnt_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GAP;
                    w_ncs_nxt   = 1'b1;
                    w_copi_nxt  = 1'b0;
                end
            end

            S_GAP: begin
                if (!w_cnt_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sclk = r_sclk;
    assign bus.copi = r_copi;
    assign bus.ncs  = r_ncs;

endmodule

`default_nettype wire

// File: tb/tb_spi_controller.sv
// ============================================================================
// Module      : tb_spi_controller
// Description : Scoreboard bench for spi_controller at CLK_DIV 8 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_controller;

    localparam int c_D0 = 8;
    localparam int c_D1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_controller_if bus0 ();
    spi_controller_if bus1 ();

    spi_controller #(.CLK_DIV(c_D0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    spi_controller #(.CLK_DIV(c_D1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic       s_start [2];
    logic       s_rw    [2];
    logic [6:0] s_addr  [2];
    logic [7:0] s_wdata [2];
    logic       s_end;
    int         s_timeouts;

    assign bus0.start = s_start[0];
    assign bus0.rw    = s_rw[0];
    assign bus0.addr  = s_addr[0];
    assign bus0.wdata = s_wdata[0];
    assign bus1.start = s_start[1];
    assign bus1.rw    = s_rw[1];
    assign bus1.addr  = s_addr[1];
    assign bus1.wdata = s_wdata[1];

    logic w_ncs [2], w_busy [2], w_done [2], w_sclk [2], w_copi [2];
    assign w_ncs[0]  = bus0.ncs;
    assign w_busy[0] = bus0.busy;
    assign w_done[0] = bus0.done;
    assign w_sclk[0] = bus0.sclk;
    assign w_copi[0] = bus0.copi;
    assign w_ncs[1]  = bus1.ncs;
    assign w_busy[1] = bus1.busy;
    assign w_done[1] = bus1.done;
    assign w_sclk[1] = bus1.sclk;
    assign w_copi[1] = bus1.copi;

    typedef struct {
        int          inst;
        logic [15:0] frame;
    } exp_t;
    exp_t exp_q [$];

    // Monitor / scoreboard state
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycles  = 0;
    int          t       [2];
    bit          active  [2];
    logic [15:0] f_cur   [2];
    int          rises   [2];
    logic [15:0] cap     [2];
    logic        prev_sclk [2];
    logic [7:0]  periph  [2][5] = '{default: 8'h00};
    logic [7:0]  model   [2][5] = '{default: 8'h00};

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0d got=0x%0h want=0x%0h", nm, i, t[i], act, exp);
        end
    endtask

    always @(negedge clk) begin
        cycles++;
        for (int i = 0; i < 2; i++) begin
            int          d;
            int          k;
            logic [4:0]  pins;
            logic [4:0]  ep;
            exp_t        e;
            d    = (i == 0) ? c_D0 : c_D1;
            pins = {w_ncs[i], w_busy[i], w_done[i], w_sclk[i], w_copi[i]};
            if (rst) begin
                chk("reset_pins", i, int'(pins), int'(5'b10000));
                if (active[i]) begin
                    active[i] = 1'b0;
                    for (int r = 0; r < 5; r++)
                        chk("reset_regs", i, int'(periph[i][r]), int'(model[i][r]));
                end
            end else begin
                if (active[i]) begin
                    t[i]++;
                    k     = (t[i] - 1) / (2 * d);
                    ep[4] = (t[i] >= 33 * d + 1);
                    ep[3] = (t[i] <= 34 * d);
                    ep[2] = (t[i] == 34 * d + 1);
                    ep[1] = (t[i] <= 32 * d) && ((((t[i] - 1) / d) % 2) == 1);
                    if (t[i] <= 32 * d)      ep[0] = f_cur[i][15 - k];
                    else if (t[i] <= 33 * d) ep[0] = f_cur[i][0];
                    else                     ep[0] = 1'b0;
                    chk("pins", i, int'(pins), int'(ep));
                    if (w_sclk[i] && !prev_sclk[i] && !w_ncs[i]) begin
                        rises[i]++;
                        cap[i] = {cap[i][14:0], w_copi[i]};
                    end
                    if (t[i] == 33 * d + 1) begin
                        chk("rises", i, rises[i], 16);
                        chk("frame", i, int'(cap[i]), int'(f_cur[i]));
                        if (rises[i] == 16 && cap[i][15] && cap[i][14:8] <= 7'd4)
                            periph[i][int'(cap[i][14:8])] = cap[i][7:0];
                        if (f_cur[i][15] && f_cur[i][14:8] <= 7'd4)
                            model[i][int'(f_cur[i][14:8])] = f_cur[i][7:0];
                    end
                    if (t[i] == 34 * d + 1) begin
                        chk("en_reg_out_7_0", i, int'(periph[i][0]), int'(model[i][0]));
                        chk("pwm_duty_cycle", i, int'(periph[i][4]), int'(model[i][4]));
                        for (int r = 1; r < 4; r++)
                            chk("periph_reg", i, int'(periph[i][r]), int'(model[i][r]));
                        active[i] = 1'b0;
                    end
                end else begin
                    chk("idle_pins", i, int'(pins), int'(5'b10000));
                end
                if (s_start[i] && !w_busy[i]) begin
                    chk("accept_pending", i, exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("accept_inst", i, e.inst, i);
                        f_cur[i]  = e.frame;
                        active[i] = 1'b1;
                        t[i]      = 0;
                        rises[i]  = 0;
                        cap[i]    = 16'h0000;
                    end
                end
            end
            prev_sclk[i] = w_sclk[i];
        end
        if (cycles > 60000) chk("watchdog", 0, cycles, 60000);
        if (s_end || cycles > 60000) begin
            chk("queue_empty", 0, exp_q.size(), 0);
            chk("timeouts", 0, s_timeouts, 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    task automatic wait_idle(input int i);
        int n = 0;
        while (w_busy[i] && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (w_busy[i]) s_timeouts++;
    endtask

    task automatic scramble(input int i);
        s_rw[i]    = 1'($urandom);
        s_addr[i]  = 7'($urandom);
        s_wdata[i] = 8'($urandom);
    endtask

    task automatic send(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        wait_idle(i);
        s_rw[i]    = rw;
        s_addr[i]  = a;
        s_wdata[i] = d;
        s_start[i] = 1'b1;
        exp_q.push_back('{i, {rw, a, d}});
        @(posedge clk); #1;
        s_start[i] = 1'b0;
        scramble(i);
    endtask

    task automatic pulse_ignored(input int i);
        s_start[i] = 1'b1;
        s_rw[i]    = 1'b1;
        s_addr[i]  = 7'h01;
        s_wdata[i] = 8'($urandom);
        @(posedge clk); #1;
        s_start[i] = 1'b0;
    endtask

    task automatic send_b2b(input int i, input logic [15:0] f1, input logic [15:0] f2);
        wait_idle(i);
        {s_rw[i], s_addr[i], s_wdata[i]} = f1;
        s_start[i] = 1'b1;
        exp_q.push_back('{i, f1});
        @(posedge clk); #1;
        {s_rw[i], s_addr[i], s_wdata[i]} = f2;
        exp_q.push_back('{i, f2});
        wait_idle(i);
        @(posedge clk); #1;
        s_start[i] = 1'b0;
        scramble(i);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_start[i] = 1'b0;
            s_rw[i]    = 1'b0;
            s_addr[i]  = 7'h00;
            s_wdata[i] = 8'h00;
        end
        s_end      = 1'b0;
        s_timeouts = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single write, then loopback register sequence
        send(0, 1'b1, 7'h04, 8'h80);
        wait_idle(0);
        send(0, 1'b1, 7'h00, 8'hF0);
        send(0, 1'b1, 7'h04, 8'h80);
        send(0, 1'b0, 7'h00, 8'h55);
        wait_idle(0);

        // start pulses while busy must be ignored
        send(0, 1'b1, 7'h02, 8'hAA);
        repeat (4) @(posedge clk);
        #1 pulse_ignored(0);
        repeat (93) @(posedge clk);
        #1 pulse_ignored(0);
        wait_idle(0);
        repeat (3) @(posedge clk);
        #1;

        send_b2b(0, 16'h8311, 16'h8422);
        wait_idle(0);

        // reset in the middle of a frame
        send(0, 1'b1, 7'h01, 8'h3C);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        send(0, 1'b1, 7'h01, 8'hFF);
        wait_idle(0);

        // minimum divider
        send(1, 1'b1, 7'h03, 8'hC3);
        wait_idle(1);

        for (int n = 0; n < 12; n++) begin
            int          inst;
            logic        rw;
            logic [6:0]  a;
            inst = $urandom_range(0, 1);
            rw   = ($urandom_range(0, 3) != 0);
            a    = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(0, 4)) : 7'($urandom);
            send(inst, rw, a, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle(0);
        wait_idle(1);
        repeat (5) @(posedge clk);
        #1 s_end = 1'b1;
    end

endmodule

`default_nettype wire
